// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module  : alu_arbiter_if
// Purpose : Requester, response, shared-ALU and grant-count signals of alu_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
    parameter int CNT_W = 16
);
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [3:0]       req0_op, req1_op;
    logic [31:0]      req0_a, req0_b, req1_a, req1_b;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready, rsp1_ready;
    logic [31:0]      rsp0_result, rsp1_result;
    logic             rsp0_zero, rsp1_zero, rsp0_less, rsp1_less;
    logic [3:0]       alu_op;
    logic [31:0]      alu_in1, alu_in2, alu_result;
    logic             alu_zero, alu_less;
    logic [CNT_W-1:0] gnt_cnt0, gnt_cnt1;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_result, alu_zero, alu_less,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
               rsp0_less, rsp1_less, alu_op, alu_in1, alu_in2,
               gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
               req0_a, req0_b, req1_a, req1_b,
               rsp0_ready, rsp1_ready, alu_result, alu_zero, alu_less,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp0_result, rsp1_result, rsp0_zero, rsp1_zero,
               rsp0_less, rsp1_less, alu_op, alu_in1, alu_in2,
               gnt_cnt0, gnt_cnt1
    );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module  : alu_arbiter
// Purpose : Round-robin arbiter sharing one combinational ALU between two requesters.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic             r_owner, r_last_gnt;
    logic [3:0]       r_op;
    logic [31:0]      r_a, r_b;
    logic [31:0]      r_res0, r_res1;
    logic             r_zero0, r_zero1, r_less0, r_less1;
    logic [CNT_W-1:0] r_cnt0, r_cnt1;

    logic             w_gnt0, w_gnt1, w_accept, w_legal, w_rsp_hs;
    logic [31:0]      w_cap_res;
    logic             w_cap_zero, w_cap_less;

    assign w_legal    = (r_op <= 4'd4);
    assign w_accept   = w_gnt0 | w_gnt1;
    assign w_rsp_hs   = r_owner ? bus.rsp1_ready : bus.rsp0_ready;
    // Unsupported opcodes never see the ALU; they complete with a fixed zero result.
    assign w_cap_res  = w_legal ? bus.alu_result : 32'd0;
    assign w_cap_zero = w_legal ? bus.alu_zero   : 1'b1;
    assign w_cap_less = w_legal ? bus.alu_less   : 1'b0;

    always_comb begin
        w_next      = r_state;
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        bus.alu_op  = 4'd0;
        bus.alu_in1 = 32'd0;
        bus.alu_in2 = 32'd0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    // On a tie the requester not served last wins.
                    w_gnt0 = bus.req0_valid & (~bus.req1_valid | r_last_gnt);
                    w_gnt1 = bus.req1_valid & (~bus.req0_valid | ~r_last_gnt);
                end
                if (w_gnt0 | w_gnt1)
                    w_next = ISSUE;
            end
            ISSUE: begin
                if (w_legal) begin
                    bus.alu_op  = r_op;
                    bus.alu_in1 = r_a;
                    bus.alu_in2 = r_b;
                end
                w_next = RESP;
            end
            RESP: begin
                if (w_rsp_hs)
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign bus.req0_ready  = w_gnt0;
    assign bus.req1_ready  = w_gnt1;
    assign bus.rsp0_valid  = (r_state == RESP) & ~r_owner;
    assign bus.rsp1_valid  = (r_state == RESP) &  r_owner;
    assign bus.rsp0_result = r_res0;
    assign bus.rsp1_result = r_res1;
    assign bus.rsp0_zero   = r_zero0;
    assign bus.rsp1_zero   = r_zero1;
    assign bus.rsp0_less   = r_less0;
    assign bus.rsp1_less   = r_less1;
    assign bus.gnt_cnt0    = r_cnt0;
    assign bus.gnt_cnt1    = r_cnt1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_last_gnt <= 1'b1;
            r_op       <= 4'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_res0     <= 32'd0;
            r_res1     <= 32'd0;
            r_zero0    <= 1'b0;
            r_zero1    <= 1'b0;
            r_less0    <= 1'b0;
            r_less1    <= 1'b0;
            r_cnt0     <= '0;
            r_cnt1     <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner    <= w_gnt1;
                r_last_gnt <= w_gnt1;
                r_op       <= w_gnt1 ? bus.req1_op : bus.req0_op;
                r_a        <= w_gnt1 ? bus.req1_a  : bus.req0_a;
                r_b        <= w_gnt1 ? bus.req1_b  : bus.req0_b;
                if (w_gnt1) begin
                    if (r_cnt1 != '1)
                        r_cnt1 <= r_cnt1 + 1'b1;
                end else begin
                    if (r_cnt0 != '1)
                        r_cnt0 <= r_cnt0 + 1'b1;
                end
            end
            if (r_state == ISSUE) begin
                if (r_owner) begin
                    r_res1  <= w_cap_res;
                    r_zero1 <= w_cap_zero;
                    r_less1 <= w_cap_less;
                end else begin
                    r_res0  <= w_cap_res;
                    r_zero0 <= w_cap_zero;
                    r_less0 <= w_cap_less;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module  : tb_alu_arbiter
// Purpose : Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;
    logic clk;
    logic rst;
    logic alu_junk;
    logic [31:0] alu_r;
    int n_total;
    int n_bad;

    alu_arbiter_if #(.CNT_W(2)) bus ();

    alu_arbiter #(.CNT_W(2)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared ALU; alu_junk makes it emit garbage to prove its outputs are ignored.
    always_comb begin
        alu_r = 32'd0;
        case (bus.alu_op)
            4'd0: alu_r = bus.alu_in1 + bus.alu_in2;
            4'd1: alu_r = bus.alu_in1 - bus.alu_in2;
            4'd2: alu_r = bus.alu_in1 << bus.alu_in2[4:0];
            4'd3: alu_r = bus.alu_in1 >> bus.alu_in2[4:0];
            4'd4: alu_r = {31'd0, $signed(bus.alu_in1) < $signed(bus.alu_in2)};
            default: alu_r = 32'd0;
        endcase
        if (alu_junk) begin
            bus.alu_result = 32'h5A5A_5A5A;
            bus.alu_zero   = 1'b0;
            bus.alu_less   = 1'b1;
        end else begin
            bus.alu_result = alu_r;
            bus.alu_zero   = (alu_r == 32'd0);
            bus.alu_less   = alu_r[31];
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input bit n, input bit v, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        if (n) begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end
    endtask

    // Accept, issue and respond for one lone request; starts and ends just after a rising edge.
    task automatic run_single(input bit n, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [3:0] eop,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic [31:0] eres, input logic ez, input logic el,
                              input string tag);
        drive_req(n, 1'b1, op, a, b);
        @(negedge clk);
        check_value({tag, "_rdy"}, n ? bus.req1_ready : bus.req0_ready, 1);
        next_cycle();
        drive_req(n, 1'b0, ~op, ~a, ~b);
        @(negedge clk);
        check_value({tag, "_op"},  bus.alu_op,  eop);
        check_value({tag, "_in1"}, bus.alu_in1, e1);
        check_value({tag, "_in2"}, bus.alu_in2, e2);
        next_cycle();
        @(negedge clk);
        check_value({tag, "_vld"},  n ? bus.rsp1_valid  : bus.rsp0_valid,  1);
        check_value({tag, "_oth"},  n ? bus.rsp0_valid  : bus.rsp1_valid,  0);
        check_value({tag, "_res"},  n ? bus.rsp1_result : bus.rsp0_result, eres);
        check_value({tag, "_zero"}, n ? bus.rsp1_zero   : bus.rsp0_zero,   ez);
        check_value({tag, "_less"}, n ? bus.rsp1_less   : bus.rsp0_less,   el);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] sat_exp [5];
        sat_exp = '{1, 2, 3, 3, 3};
        n_total = 0;
        n_bad   = 0;
        alu_junk = 1'b0;
        rst = 1'b1;
        drive_req(0, 1'b1, 4'd0, 32'd9, 32'd9);
        drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        bus.rsp0_ready = 1'b1;
        bus.rsp1_ready = 1'b1;

        // Reset state, with a request pending that must not be accepted
        repeat (2) next_cycle();
        @(negedge clk);
        check_value("rst_rdy0", bus.req0_ready, 0);
        check_value("rst_vld0", bus.rsp0_valid, 0);
        check_value("rst_vld1", bus.rsp1_valid, 0);
        check_value("rst_cnt0", bus.gnt_cnt0, 0);
        check_value("rst_cnt1", bus.gnt_cnt1, 0);
        check_value("rst_res0", bus.rsp0_result, 0);
        check_value("rst_zero1", bus.rsp1_zero, 0);
        check_value("rst_aluop", bus.alu_op, 0);
        next_cycle();
        rst = 1'b0;
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);

        // Tie straight after reset: requester 0 goes first
        next_cycle();
        drive_req(0, 1'b1, 4'd1, 32'd3, 32'd3);
        drive_req(1, 1'b1, 4'd4, 32'd1, 32'd2);
        @(negedge clk);
        check_value("tie_rdy0", bus.req0_ready, 1);
        check_value("tie_rdy1", bus.req1_ready, 0);
        next_cycle();
        drive_req(0, 1'b0, 4'd0, 32'hDEAD, 32'hBEEF);
        @(negedge clk);
        check_value("sub_op", bus.alu_op, 1);
        check_value("sub_in1", bus.alu_in1, 3);
        check_value("sub_in2", bus.alu_in2, 3);
        check_value("sub_rdy1", bus.req1_ready, 0);
        next_cycle();
        @(negedge clk);
        check_value("sub_vld0", bus.rsp0_valid, 1);
        check_value("sub_vld1", bus.rsp1_valid, 0);
        check_value("sub_res", bus.rsp0_result, 0);
        check_value("sub_zero", bus.rsp0_zero, 1);
        check_value("sub_less", bus.rsp0_less, 0);
        check_value("hs_rdy1", bus.req1_ready, 0);
        next_cycle();
        @(negedge clk);
        check_value("slt_rdy1", bus.req1_ready, 1);
        next_cycle();
        drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_value("slt_op", bus.alu_op, 4);
        check_value("slt_in1", bus.alu_in1, 1);
        check_value("slt_in2", bus.alu_in2, 2);
        next_cycle();
        @(negedge clk);
        check_value("slt_vld1", bus.rsp1_valid, 1);
        check_value("slt_vld0", bus.rsp0_valid, 0);
        check_value("slt_res", bus.rsp1_result, 1);
        check_value("slt_zero", bus.rsp1_zero, 0);
        check_value("hold_res0", bus.rsp0_result, 0);
        check_value("hold_zero0", bus.rsp0_zero, 1);
        next_cycle();

        // Second tie: requester 1 was served last, so requester 0 wins again
        drive_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
        drive_req(1, 1'b1, 4'd3, 32'h8000_0000, 32'd4);
        bus.rsp1_ready = 1'b0;
        @(negedge clk);
        check_value("rr_rdy0", bus.req0_ready, 1);
        check_value("rr_rdy1", bus.req1_ready, 0);
        next_cycle();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        @(negedge clk);
        check_value("add_op", bus.alu_op, 0);
        check_value("add_in1", bus.alu_in1, 5);
        check_value("add_in2", bus.alu_in2, 7);
        next_cycle();
        @(negedge clk);
        check_value("add_vld0", bus.rsp0_valid, 1);
        check_value("add_res", bus.rsp0_result, 12);
        check_value("add_zero", bus.rsp0_zero, 0);
        check_value("add_less", bus.rsp0_less, 0);
        check_value("add_cnt0", bus.gnt_cnt0, 2);
        next_cycle();
        @(negedge clk);
        check_value("srl_rdy1", bus.req1_ready, 1);
        next_cycle();
        drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0);
        next_cycle();

        // Backpressure on requester 1 while requester 0 waits with an unsupported op
        drive_req(0, 1'b1, 4'b1010, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("bp_vld1", bus.rsp1_valid, 1);
            check_value("bp_res1", bus.rsp1_result, 32'h0800_0000);
            check_value("bp_rdy0", bus.req0_ready, 0);
            check_value("bp_rdy1", bus.req1_ready, 0);
            next_cycle();
        end
        bus.rsp1_ready = 1'b1;
        @(negedge clk);
        check_value("bp_hs_rdy0", bus.req0_ready, 0);
        next_cycle();
        @(negedge clk);
        check_value("bp_idle_vld1", bus.rsp1_valid, 0);
        check_value("ill_rdy0", bus.req0_ready, 1);
        next_cycle();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        alu_junk = 1'b1;
        @(negedge clk);
        check_value("ill_op", bus.alu_op, 0);
        check_value("ill_in1", bus.alu_in1, 0);
        check_value("ill_in2", bus.alu_in2, 0);
        next_cycle();
        @(negedge clk);
        check_value("ill_vld0", bus.rsp0_valid, 1);
        check_value("ill_res", bus.rsp0_result, 0);
        check_value("ill_zero", bus.rsp0_zero, 1);
        check_value("ill_less", bus.rsp0_less, 0);
        check_value("ill_hold1", bus.rsp1_result, 32'h0800_0000);
        check_value("ill_cnt0", bus.gnt_cnt0, 3);
        check_value("ill_cnt1", bus.gnt_cnt1, 2);
        next_cycle();
        alu_junk = 1'b0;

        // Reset while the operation is in ISSUE
        drive_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
        @(negedge clk);
        check_value("mid_rdy0", bus.req0_ready, 1);
        next_cycle();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_value("mid_vld0", bus.rsp0_valid, 0);
        check_value("mid_vld1", bus.rsp1_valid, 0);
        check_value("mid_cnt0", bus.gnt_cnt0, 0);
        check_value("mid_cnt1", bus.gnt_cnt1, 0);
        check_value("mid_res1", bus.rsp1_result, 0);
        check_value("mid_aluop", bus.alu_op, 0);
        next_cycle();
        @(negedge clk);
        check_value("mid_idle_vld0", bus.rsp0_valid, 0);
        next_cycle();
        run_single(1, 4'd2, 32'd1, 32'd31, 4'd2, 32'd1, 32'd31,
                   32'h8000_0000, 1'b0, 1'b1, "sll");

        // Counter saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            run_single(0, 4'd0, i, 32'd1, 4'd0, i, 32'd1, i + 1, 1'b0, 1'b0, "sat");
            @(negedge clk);
            check_value("sat_cnt0", bus.gnt_cnt0, sat_exp[i]);
            next_cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: CNT_W, default 16, width of each per-requester grant counter.
REQ-002 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: reqN_valid  in  1  (N=0,1) requester N presents an operation.
REQ-005 Port: reqN_ready  out  1  arbiter accepts requester N this cycle.
REQ-006 Port: reqN_op  in  4  ALU opcode: 0000 add, 0001 sub, 0010 sll, 0011 srl, 0100 slt.
REQ-007 Port: reqN_a, reqN_b  in  32 each  operands; reqN_a drives in1, reqN_b drives in2.
REQ-008 Port: rspN_valid  out  1  response for requester N is held.
REQ-009 Port: rspN_ready  in  1  requester N consumes the response.
REQ-010 Port: rspN_result  out  32, rspN_zero  out  1, rspN_less  out  1  captured ALU outputs.
REQ-011 Port: alu_op  out  4, alu_in1  out  32, alu_in2  out  32  drive the shared ALU.
REQ-012 Port: alu_result  in  32, alu_zero  in  1, alu_less  in  1  from the shared ALU (combinational).
REQ-013 Port: gnt_cntN  out  CNT_W  number of requests accepted from requester N, saturating.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and RESP; one operation is in flight at a time.
REQ-015 reqN_ready SHALL be high only in IDLE, for at most one N per cycle; it may depend combinationally on both valids.
REQ-016 In IDLE with exactly one valid: that requester SHALL be granted.
REQ-017 In IDLE with both valid: the requester other than last_gnt SHALL be granted (round robin).
REQ-018 On acceptance (valid & ready) the arbiter SHALL register op, a, b and owner, set last_gnt=owner, increment gnt_cnt[owner] unless it equals all-ones, and go to ISSUE.
REQ-019 In ISSUE, alu_op/alu_in1/alu_in2 SHALL be driven from the registered values; the arbiter SHALL capture alu_result/zero/less at the end of the cycle and go to RESP.
REQ-020 Outside ISSUE, alu_op, alu_in1 and alu_in2 SHALL be driven to 0.
REQ-021 Ops 0101-1111 SHALL be accepted; in ISSUE the ALU outputs are ignored and result=0, zero=1, less=0 are captured; alu_* stays 0.
REQ-022 In RESP, rsp[owner]_valid SHALL be high, the other rspN_valid low, and result/zero/less stable until handshake.
REQ-023 rsp[owner]_valid & rsp[owner]_ready SHALL return the FSM to IDLE on the next cycle; no new request is accepted in the handshake cycle.
REQ-024 Minimum latency: accept in cycle T, rspN_valid high in T+2; minimum throughput: one operation every 3 cycles.
REQ-025 rspN_result/zero/less of the non-owner SHALL hold their last captured values; only the owner's registers update.
REQ-026 Changes to reqN_op/a/b after acceptance SHALL NOT affect the in-flight operation.

Reset
REQ-027 When rst is high at a clock edge: state=IDLE, rsp0_valid=rsp1_valid=0, all rspN_result=0, rspN_zero=0, rspN_less=0, gnt_cnt0=gnt_cnt1=0, last_gnt=1 (requester 0 wins the first tie).
REQ-028 Reset in ISSUE or RESP SHALL abort the operation with no response delivered; reqN_ready SHALL be low in any cycle with rst high.

Verification
REQ-029 Single request: req0 add a=5, b=7 accepted in T -> alu_op=0000, in1=5, in2=7 in T+1; rsp0_valid in T+2 with result=12, zero=0, less=0; gnt_cnt0=1.
REQ-030 Tie after reset: both valid, req0 sub 3-3, req1 slt 1<2 -> req0 first (result=0, zero=1), then req1 (result=1); both valid again -> req0 wins because last_gnt=1.
REQ-031 Backpressure: req1 srl 0x80000000>>4 with rsp1_ready low for 5 cycles -> rsp1_valid and result=0x08000000 held constant and both reqN_ready low throughout; IDLE the cycle after rsp1_ready rises.
REQ-032 Illegal op: req0 op=1010, a=0xFFFFFFFF -> alu_* stays 0; rsp0 result=0, zero=1, less=0.
REQ-033 Reset mid-operation: rst asserted in ISSUE -> next cycle IDLE, no rspN_valid, counters 0; a subsequent req1 sll 1<<31 returns 0x80000000, less=1.
REQ-034 Saturation: with CNT_W=2, 5 accepted req0 operations -> gnt_cnt0 reads 1, 2, 3, 3, 3.
